rv32_multicycle_ctrl: RTL and testbench
=======================================

Name: rv32_multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the RV32I integer core: fetch, decode, execute and writeback. Supported classes are OP (R-type ALU), OP-IMM (I-type ALU) and BRANCH. It owns the PC, the instruction register and the instruction-memory handshake. It strobes the instruction decoder, samples the ALU and branch comparator, drives the register-file write port, and enters a sticky trap on faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_TIMEOUT, 16, max cycles in FETCH without imem_ack before timeout trap (>=2)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request, high only in FETCH
imem_addr  output  32  fetch address, equals pc
imem_ack  input  1  instruction valid on imem_rdata this cycle
imem_rdata  input  32  fetched instruction word
ir  output  32  latched instruction register, feeds decoder
dec_en  output  1  decoder enable, high only in DECODE and EXECUTE
invalid_instruction  input  1  decoder flag, sampled in DECODE
alu_result  input  32  ALU output, sampled in EXECUTE
branch_taken  input  1  comparator result, sampled in EXECUTE
rf_we  output  1  register-file write strobe
rf_waddr  output  5  write address (ir[11:7])
rf_wdata  output  32  write data
pc  output  32  current program counter
trap  output  1  sticky fault flag
trap_cause  output  2  01 illegal, 10 fetch timeout, 11 misaligned branch target
instret  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- States: FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
- Reset (rst=1 at edge):
  - state=FETCH, pc=RESET_PC, ir=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - trap=0, trap_cause=0, timeout counter=0, instret=0.
  - Reset in any state, including TRAP, aborts the instruction with no writeback.
- Outputs imem_req and dec_en are decoded from state; all other outputs are registered.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - An ack in the same cycle as req is accepted: ir<=imem_rdata, go to DECODE, clear the counter.
  - Each cycle without ack increments the counter.
  - If the counter reaches IMEM_TIMEOUT-1 with no ack: go to TRAP, cause=10.
  - An ack in that final cycle wins over the timeout.
  - imem_ack outside FETCH is ignored.
- DECODE (1 cycle):
  - Trap with cause=01 if invalid_instruction=1, or ir[1:0]!=2'b11, or ir[6:2] is not in {01100, 00100, 11000}.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle):
  - OP/OP-IMM: rf_wdata<=alu_result, rf_waddr<=ir[11:7], go to WRITEBACK.
  - BRANCH: target = pc + sext({ir[31],ir[7],ir[30:25],ir[11:8],1'b0}), modulo 2^32.
  - If branch_taken and target[1:0]!=0: TRAP, cause=11, pc unchanged.
  - If taken and aligned: pc<=target. Not taken: pc<=pc+4. Then go to FETCH and retire.
- WRITEBACK (1 cycle):
  - rf_we=1 for exactly this cycle, except rd==0 forces rf_we=0.
  - pc<=pc+4 (wraps 32'hFFFF_FFFC -> 0), go to FETCH and retire.
- TRAP:
  - Absorbing: imem_req=0, rf_we=0, pc frozen, trap=1, trap_cause held.
  - Exit only by rst.
- Minimum CPI with zero-wait memory: branch 3, ALU 4.
- rf_we is never high outside WRITEBACK.

Optional Feature:
Macro CTRL_INSTRET_EN.
- Defined: instret increments by 1 on each retirement (WRITEBACK exit or branch EXECUTE exit without trap). Wraps at 2^32. Reset to 0.
- Undefined: instret is constant 0 and the counter logic is absent.

Test Plan:
1. Reset, imem_rdata=32'h00500093 (addi x1,x0,5), ack on first req cycle, alu_result=5 -> rf_we pulses in 4th cycle after FETCH entry with waddr=1, wdata=5; next FETCH at pc=4; instret=1 (macro on).
2. pc=0x10, ir=32'h00000463 (beq x0,x0,8), branch_taken=1 -> pc=0x18 after EXECUTE, rf_we never asserts. Same word with branch_taken=0 -> pc=0x14.
3. ir=32'h00000363 (beq offset 6), branch_taken=1 -> trap=1, trap_cause=11, pc stays 0x10. Not-taken variant retires normally.
4. imem_ack held 0 -> trap with cause=10 after exactly IMEM_TIMEOUT FETCH cycles, imem_req then 0. A repeat with ack in cycle IMEM_TIMEOUT -> normal DECODE.
5. imem_rdata=32'h00000000 -> trap_cause=01. rst asserted in TRAP -> pc=RESET_PC, trap=0, imem_req=1 next cycle.
6. add x0,x1,x2 (32'h00208033) -> no rf_we, pc advances by 4, instret increments. Reset asserted during WRITEBACK of a prior ALU op -> rf_we low next cycle.

Source files
------------

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM (OP, OP-IMM, BRANCH) owning PC, IR, imem handshake and sticky trap.
// Optional retired-instruction counter enabled by defining CTRL_INSTRET_EN.
module rv32_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        dec_en,
  input  logic        invalid_instruction,
  input  logic [31:0] alu_result,
  input  logic        branch_taken,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  // state     | meaning
  // S_FETCH   | imem request outstanding, waiting for ack or timeout
  // S_DECODE  | opcode legality check on latched IR
  // S_EXECUTE | sample ALU / branch comparator
  // S_WRITEBACK | register-file write strobe, advance PC
  // S_TRAP    | sticky fault, left only through rst
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_TRAP
  } state_e;

  localparam int CW = $clog2(IMEM_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(IMEM_TIMEOUT - 1);

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          trap_q, trap_d;
  logic [1:0]    cause_q, cause_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [4:0]  opc;
  logic [31:0] br_imm;
  logic [31:0] br_target;
  logic        br_misaligned;

  assign opc           = ir_q[6:2];
  assign br_imm        = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign br_target     = pc_q + br_imm;
  assign br_misaligned = branch_taken && (br_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      trap_q     <= 1'b0;
      cause_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_FETCH: begin
        // an ack in the final allowed cycle takes priority over the timeout
        if (imem_ack) begin
          ir_d    = imem_rdata;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else if (cnt_q == TO_LAST) begin
          trap_d  = 1'b1;
          cause_d = 2'b10;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (invalid_instruction || (ir_q[1:0] != 2'b11) ||
            !(opc inside {OPC_OP, OPC_OP_IMM, OPC_BRANCH})) begin
          trap_d  = 1'b1;
          cause_d = 2'b01;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (opc == OPC_BRANCH) begin
          if (br_misaligned) begin
            trap_d  = 1'b1;
            cause_d = 2'b11;
            state_d = S_TRAP;
          end else begin
            pc_d    = branch_taken ? br_target : pc_q + 32'd4;
            state_d = S_FETCH;
          end
        end else begin
          rf_wdata_d = alu_result;
          rf_waddr_d = ir_q[11:7];
          rf_we_d    = (ir_q[11:7] != 5'd0);
          state_d    = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        pc_d    = pc_q + 32'd4;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

`ifdef CTRL_INSTRET_EN
  logic        retire;
  logic [31:0] instret_q;

  assign retire = (state_q == S_WRITEBACK) ||
                  ((state_q == S_EXECUTE) && (opc == OPC_BRANCH) && !br_misaligned);

  always_ff @(posedge clk) begin
    if (rst)         instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dec_en     = (state_q == S_DECODE) || (state_q == S_EXECUTE);
  assign ir         = ir_q;
  assign pc         = pc_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed bench for rv32_multicycle_ctrl; instret expectations follow CTRL_INSTRET_EN.
module tb_rv32_multicycle_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        dec_en;
  logic        invalid_instruction;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pc;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  int retired = 0;

  rv32_multicycle_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .dec_en(dec_en), .invalid_instruction(invalid_instruction),
    .alu_result(alu_result), .branch_taken(branch_taken),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc(pc), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_instret();
`ifdef CTRL_INSTRET_EN
    return 32'(retired);
`else
    return 32'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    retired = 0;
  endtask

  // One full ALU instruction starting in FETCH at pc0
  task automatic run_alu(input logic [31:0] word, input logic [31:0] alu, input logic [31:0] pc0);
    logic [4:0] rd;
    rd = word[11:7];
    imem_rdata = word;
    alu_result = alu;
    chk("alu_fetch_req", {31'd0, imem_req}, 32'd1);
    chk("alu_fetch_addr", imem_addr, pc0);
    step();
    chk("alu_decode_en", {31'd0, dec_en}, 32'd1);
    chk("alu_decode_ir", ir, word);
    step();
    chk("alu_exec_we", {31'd0, rf_we}, 32'd0);
    step();
    chk("alu_wb_we", {31'd0, rf_we}, {31'd0, rd != 5'd0});
    chk("alu_wb_waddr", {27'd0, rf_waddr}, {27'd0, rd});
    chk("alu_wb_wdata", rf_wdata, alu);
    chk("alu_wb_pc", pc, pc0);
    step();
    retired++;
    chk("alu_next_we", {31'd0, rf_we}, 32'd0);
    chk("alu_next_pc", pc, pc0 + 32'd4);
    chk("alu_next_req", {31'd0, imem_req}, 32'd1);
    chk("alu_instret", instret, exp_instret());
  endtask

  // One branch starting in FETCH at pc0; exp_pc/exp_trap hand-computed by caller
  task automatic run_branch(input logic [31:0] word, input logic taken, input logic [31:0] pc0,
                            input logic [31:0] exp_pc, input logic exp_trap, input logic [1:0] exp_cause);
    imem_rdata = word;
    branch_taken = 1'b0;
    chk("br_fetch_addr", imem_addr, pc0);
    step();
    branch_taken = taken;
    step();
    chk("br_exec_we", {31'd0, rf_we}, 32'd0);
    chk("br_exec_en", {31'd0, dec_en}, 32'd1);
    step();
    branch_taken = 1'b0;
    if (!exp_trap) retired++;
    chk("br_pc", pc, exp_pc);
    chk("br_trap", {31'd0, trap}, {31'd0, exp_trap});
    chk("br_cause", {30'd0, trap_cause}, {30'd0, exp_cause});
    chk("br_we", {31'd0, rf_we}, 32'd0);
    chk("br_req", {31'd0, imem_req}, {31'd0, !exp_trap});
    chk("br_instret", instret, exp_instret());
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'd0;
    invalid_instruction = 1'b0;
    alu_result = 32'd0;
    branch_taken = 1'b0;
    step();
    do_reset();

    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_cause", {30'd0, trap_cause}, 32'd0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_dec_en", {31'd0, dec_en}, 32'd0);
    chk("rst_instret", instret, 32'd0);

    run_alu(32'h0050_0093, 32'd5, 32'h0);          // addi x1,x0,5
    run_alu(32'h0020_8033, 32'hDEAD_BEEF, 32'h4);  // add x0,x1,x2: no write
    run_alu(32'h0070_0113, 32'd7, 32'h8);          // addi x2,x0,7
    run_alu(32'h0030_0193, 32'd3, 32'hC);          // addi x3,x0,3

    run_branch(32'h0000_0463, 1'b0, 32'h10, 32'h14, 1'b0, 2'b00); // beq +8 not taken
    run_branch(32'hFE00_0EE3, 1'b1, 32'h14, 32'h10, 1'b0, 2'b00); // beq -4 taken
    run_branch(32'h0000_0363, 1'b0, 32'h10, 32'h14, 1'b0, 2'b00); // beq +6 not taken
    run_branch(32'hFE00_0EE3, 1'b1, 32'h14, 32'h10, 1'b0, 2'b00);
    run_branch(32'h0000_0463, 1'b1, 32'h10, 32'h18, 1'b0, 2'b00); // beq +8 taken
    run_branch(32'hFE00_0CE3, 1'b1, 32'h18, 32'h10, 1'b0, 2'b00); // beq -8 taken
    run_branch(32'h0000_0363, 1'b1, 32'h10, 32'h10, 1'b1, 2'b11); // misaligned target

    step();
    step();
    chk("trap_sticky", {31'd0, trap}, 32'd1);
    chk("trap_pc_frozen", pc, 32'h10);
    chk("trap_no_req", {31'd0, imem_req}, 32'd0);
    chk("trap_cause_held", {30'd0, trap_cause}, 32'd3);

    // illegal instruction, then reset out of TRAP
    do_reset();
    imem_rdata = 32'h0000_0000;
    step();
    step();
    chk("ill_trap", {31'd0, trap}, 32'd1);
    chk("ill_cause", {30'd0, trap_cause}, 32'd1);
    chk("ill_dec_en", {31'd0, dec_en}, 32'd0);
    do_reset();
    chk("trst_pc", pc, 32'h0);
    chk("trst_trap", {31'd0, trap}, 32'd0);
    chk("trst_cause", {30'd0, trap_cause}, 32'd0);
    chk("trst_req", {31'd0, imem_req}, 32'd1);
    chk("trst_ir", ir, 32'h0);

    // decoder flag alone forces illegal trap on a legal encoding
    imem_rdata = 32'h0050_0093;
    invalid_instruction = 1'b1;
    step();
    step();
    invalid_instruction = 1'b0;
    chk("inv_flag_cause", {30'd0, trap_cause}, 32'd1);
    chk("inv_flag_trap", {31'd0, trap}, 32'd1);

    // fetch timeout after exactly TO cycles
    imem_ack = 1'b0;
    do_reset();
    for (int i = 1; i < TO; i++) begin
      step();
      chk("to_waiting", {31'd0, trap}, 32'd0);
    end
    chk("to_last_req", {31'd0, imem_req}, 32'd1);
    step();
    chk("to_trap", {31'd0, trap}, 32'd1);
    chk("to_cause", {30'd0, trap_cause}, 32'd2);
    chk("to_req_off", {31'd0, imem_req}, 32'd0);
    chk("to_pc", pc, 32'h0);

    // ack arrives in the final allowed cycle
    do_reset();
    for (int i = 1; i < TO; i++) step();
    imem_ack = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();
    chk("lateack_trap", {31'd0, trap}, 32'd0);
    chk("lateack_dec_en", {31'd0, dec_en}, 32'd1);
    chk("lateack_ir", ir, 32'h0050_0093);

    // reset during writeback suppresses the write
    do_reset();
    imem_rdata = 32'h0050_0093;
    alu_result = 32'd5;
    step();
    step();
    step();
    chk("wbrst_we_before", {31'd0, rf_we}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("wbrst_we", {31'd0, rf_we}, 32'd0);
    chk("wbrst_pc", pc, 32'h0);
    chk("wbrst_req", {31'd0, imem_req}, 32'd1);
    chk("wbrst_instret", instret, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
